// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared register-file widths and writeback arbiter constants
package wb_arbiter_pkg;

  localparam int RegAddrWidth = 5;
  localparam int RegDataWidth = 32;

  typedef logic [RegAddrWidth-1:0] RegAddrBus;
  typedef logic [RegDataWidth-1:0] RegBus;

  localparam RegBus ZeroWord = '0;

  // Width of the port-1 starvation counter; holds STARVE_MAX up to 15.
  localparam int WbStarveWidth = 4;

  typedef enum logic {
    WB_PRIO0  = 1'b0,
    WB_FORCE1 = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_starve_ctr.sv
// rtl/wb_starve_ctr.sv - port-1 starvation counter and PRIO0/FORCE1 state bit
module wb_starve_ctr
  import wb_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic valid1,
  input  logic grant1,
  output logic force1
);

  localparam logic [WbStarveWidth-1:0] CNT_MAX = WbStarveWidth'(STARVE_MAX);

  wb_state_e                state;
  logic [WbStarveWidth-1:0] starve_cnt;

  // Count cycles port 1 waits behind port 0; one forced grant once the limit is hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WB_PRIO0;
      starve_cnt <= '0;
    end else begin
      case (state)
        WB_PRIO0: begin
          // valid1 without grant1 in PRIO0 can only mean port 0 won the cycle.
          if (valid1 && !grant1) begin
            if (starve_cnt >= CNT_MAX - 4'd1) begin
              starve_cnt <= CNT_MAX;
              state      <= WB_FORCE1;
            end else begin
              starve_cnt <= starve_cnt + 4'd1;
            end
          end else begin
            starve_cnt <= '0;
          end
        end
        default: begin
          state      <= WB_PRIO0;
          starve_cnt <= '0;
        end
      endcase
    end
  end

  assign force1 = (state == WB_FORCE1);

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - two-source arbiter for the register file write port
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int ADDR_W     = RegAddrWidth,
  parameter int DATA_W     = RegDataWidth,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] data0,
  output logic              ready0,
  input  logic              valid1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  output logic              ready1,
  output logic              w_enable,
  output logic [ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0] w_data,
  output logic              starved
);

  logic force1;

  wb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_ctr (
    .clk   (clk),
    .rst   (rst),
    .valid1(valid1),
    .grant1(ready1),
    .force1(force1)
  );

  // Port 0 wins unless port 1 is being forced; the two readies are mutually exclusive.
  assign ready0 = !rst && valid0 && (!force1 || !valid1);
  assign ready1 = !rst && valid1 && (force1 || !valid0);

  assign starved = force1;

  // Register the accepted write; x0 targets are consumed without enabling the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_enable <= 1'b0;
      w_addr   <= '0;
      w_data   <= '0;
    end else if (ready0 && (addr0 != '0)) begin
      w_enable <= 1'b1;
      w_addr   <= addr0;
      w_data   <= data0;
    end else if (ready1 && (addr1 != '0)) begin
      w_enable <= 1'b1;
      w_addr   <= addr1;
      w_data   <= data1;
    end else begin
      w_enable <= 1'b0;
    end
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Shares the register file's single write port between two writeback sources.
  - Port 0: in-order execute/ALU pipeline.
  - Port 1: multi-cycle load / mul-div unit.
- Fixed priority to port 0, with an anti-starvation override for port 1.
- Registered outputs drive the register file's w_enable / w_addr / w_data directly.
- The register file's same-cycle read bypass still applies, because the write is presented one cycle after acceptance.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- STARVE_MAX, 3, consecutive denied cycles of port 1 before it is forced to win (range 1..15).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- valid0  input  1  port 0 has a write pending.
- addr0  input  ADDR_W  port 0 destination register.
- data0  input  DATA_W  port 0 write data.
- ready0  output  1  port 0 accepted this cycle.
- valid1  input  1  port 1 has a write pending.
- addr1  input  ADDR_W  port 1 destination register.
- data1  input  DATA_W  port 1 write data.
- ready1  output  1  port 1 accepted this cycle.
- w_enable  output  1  register file write enable (registered).
- w_addr  output  ADDR_W  register file write address (registered).
- w_data  output  DATA_W  register file write data (registered).
- starved  output  1  high while the FORCE1 state is active (debug/perf).

Behaviour:
- Reset:
  - Synchronous, active-high.
  - On the rst edge: w_enable=0, w_addr=0, w_data=0, state=PRIO0, starve_cnt=0.
  - While rst=1: ready0=0 and ready1=0.
  - A request that was not accepted before reset is lost; the requester re-presents it after reset.
- Handshake:
  - Transfer occurs when validN && readyN.
  - A requester holds validN, addrN and dataN stable until accepted.
  - readyN is combinational from the valids and the state; it never depends on addr or data.
  - At most one of ready0/ready1 is high in any cycle.
- States:
  - PRIO0:
    - Grant rule: valid0 → grant 0; else valid1 → grant 1; else no grant.
    - starve_cnt increments when valid1 && grant==0, saturating at STARVE_MAX.
    - starve_cnt clears to 0 when port 1 is granted or valid1=0.
    - Moves to FORCE1 on the edge where the incremented count reaches STARVE_MAX.
  - FORCE1:
    - Grants port 1 if valid1, otherwise port 0 if valid0.
    - Always returns to PRIO0 next cycle with starve_cnt=0.
    - starved=1 in this state.
- Latency:
  - A transfer accepted in cycle N produces w_enable=1, w_addr=addrN, w_data=dataN in cycle N+1.
  - The register file commits at the end of cycle N+1.
  - No grant in cycle N → w_enable=0 in cycle N+1. w_addr/w_data hold their previous values.
- x0 writes:
  - A request with addrN==0 is accepted normally (readyN=1), but w_enable stays 0 next cycle.
  - x0-targeted requests still count as grants for the starvation logic.
- Simultaneous events:
  - Both valid in PRIO0 with starve_cnt<STARVE_MAX-1 → port 0 wins and the count increments.
  - Same destination address on both ports in consecutive grants → both writes issue in grant order.
  - Ordering between ports is the requesters' responsibility.
- Throughput:
  - One write per cycle, sustained.
  - Port 1 is guaranteed a grant within STARVE_MAX+1 cycles of asserting valid1.

Decomposition:
- Shared package (Defines.vh):
  - RegAddrBus, RegBus, RegAddrWidth, ZeroWord (reused).
  - New constants WB_PRIO0=1'b0 and WB_FORCE1=1'b1.
  - New WbStarveWidth=4.
- One natural sub-module: wb_starve_ctr.
  - Contents: saturating counter plus the PRIO0/FORCE1 state bit.
  - Interface: inputs valid1, grant1; output force1.
- Grant muxing and the output register stay in wb_arbiter.

Test Plan:
1. Reset check: rst=1 for 2 cycles with valid0=valid1=1 → ready0=ready1=0. On the cycle after reset release, w_enable=0, w_addr=0, w_data=0.
2. Single port: valid0=1, addr0=5, data0=0xDEADBEEF for 1 cycle → ready0=1 that cycle. Next cycle w_enable=1, w_addr=5, w_data=0xDEADBEEF. Following cycle w_enable=0.
3. Starvation (STARVE_MAX=3): valid0 and valid1 held high continuously, with fresh data each accept.
   - Grant sequence: 0,0,0,1,0,0,0,1…
   - starved=1 exactly on the port-1 grant cycles.
   - Port 1 is never waiting more than 4 cycles.
4. x0 drop: valid1=1, addr1=0, data1=0x1234 → ready1=1. Next cycle w_enable=0. A register file read of x0 returns 0.
5. Back-to-back, same register: port 0 writes x7=0x11 in cycle N and port 1 writes x7=0x22 in cycle N+1 → w_* shows x7/0x11 then x7/0x22. Final x7=0x22.
6. Reset mid-stream: assert rst in the cycle port 1 is being granted → ready1=0. The write never appears on w_enable. After release, starve_cnt=0 and port 0 wins the first contended cycle.
